sync_fifo_flags: RTL and testbench

- Single-clock, parametrised FIFO for the same datapath as our dual-clock FIFO, used where producer and consumer share one clock.
- No pointer synchronisers or Gray coding.
- Adds programmable almost-full/almost-empty thresholds, an exact fill count, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between same-clock pipeline stages as an elastic buffer.

---
 rtl/sync_fifo_flags.sv | 135 +++++++++++++
 tb/tb_sync_fifo_flags.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with exact fill count, almost-full/almost-empty thresholds and optional FWFT read mode.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags with an err_clr input.
module sync_fifo_flags #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 3,
  parameter int AFULL_TH  = (1 << ASIZE) - 2,
  parameter int AEMPTY_TH = 1,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow,
`endif
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] FULL_C   = DEPTH[ASIZE:0];
  localparam logic [ASIZE:0] AFULL_C  = AFULL_TH[ASIZE:0];
  localparam logic [ASIZE:0] AEMPTY_C = AEMPTY_TH[ASIZE:0];

  logic [DSIZE-1:0] mem [DEPTH];

  logic [ASIZE:0]   wptr_q, wptr_d;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic [ASIZE:0]   count_q, count_d;
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic             ovalid_q, ovalid_d;

  logic wfull_w, rempty_w, wr_acc, rd_acc;

  assign wfull_w  = (count_q == FULL_C);
  // In FWFT mode the head lives in the output register, so emptiness follows its valid bit.
  assign rempty_w = (FWFT != 0) ? !ovalid_q : (count_q == '0);
  assign wr_acc   = winc && !wfull_w;
  assign rd_acc   = rinc && !rempty_w;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    ovalid_d = ovalid_q;

    if (wr_acc) wptr_d = wptr_q + 1'b1;

    if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;

    if (FWFT != 0) begin
      // rptr tracks the next memory word to move into the output register.
      if ((!ovalid_q || rd_acc) && (wptr_q != rptr_q)) begin
        rdata_d  = mem[rptr_q[ASIZE-1:0]];
        rptr_d   = rptr_q + 1'b1;
        ovalid_d = 1'b1;
      end else if (rd_acc) begin
        ovalid_d = 1'b0;
      end
    end else begin
      ovalid_d = 1'b0;
      if (rd_acc) begin
        rdata_d = mem[rptr_q[ASIZE-1:0]];
        rptr_d  = rptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      ovalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      ovalid_q <= ovalid_d;
    end
  end

  // Storage is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[wptr_q[ASIZE-1:0]] <= wdata;
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (winc && wfull_w)  ovf_d = 1'b1;
    if (rinc && rempty_w) udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`endif

  assign rdata        = rdata_q;
  assign count        = count_q;
  assign wfull        = wfull_w;
  assign rempty       = rempty_w;
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: one standard-mode and one FWFT instance on a shared clock.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst_n;
  int         nvec = 0;
  int         nerr = 0;

  logic [7:0] s_wdata, f_wdata;
  logic       s_winc, s_rinc, f_winc, f_rinc;
  logic [7:0] s_rdata, f_rdata;
  logic       s_wfull, s_rempty, s_af, s_ae;
  logic       f_wfull, f_rempty, f_af, f_ae;
  logic [3:0] s_count, f_count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic       s_err_clr, f_err_clr;
  logic       s_ovf, s_udf, f_ovf, f_udf;
`endif

  always #5 clk = ~clk;

  sync_fifo_flags #(.DSIZE(8), .ASIZE(3), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .wdata(s_wdata), .winc(s_winc), .rinc(s_rinc),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    .err_clr(s_err_clr), .overflow(s_ovf), .underflow(s_udf),
`endif
    .rdata(s_rdata), .wfull(s_wfull), .rempty(s_rempty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count)
  );

  sync_fifo_flags #(.DSIZE(8), .ASIZE(3), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wdata(f_wdata), .winc(f_winc), .rinc(f_rinc),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    .err_clr(f_err_clr), .overflow(f_ovf), .underflow(f_udf),
`endif
    .rdata(f_rdata), .wfull(f_wfull), .rempty(f_rempty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count)
  );

  task automatic s_cyc(input logic w, input logic [7:0] d, input logic r);
    s_winc = w; s_wdata = d; s_rinc = r;
    @(posedge clk); #1;
    s_winc = 1'b0; s_rinc = 1'b0;
  endtask

  task automatic f_cyc(input logic w, input logic [7:0] d, input logic r);
    f_winc = w; f_wdata = d; f_rinc = r;
    @(posedge clk); #1;
    f_winc = 1'b0; f_rinc = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    s_cyc(1'b1, 8'h33, 1'b0);
    s_cyc(1'b1, 8'h44, 1'b0);
    s_cyc(1'b1, 8'h55, 1'b0);
    s_winc = 1'b1; s_wdata = 8'h66; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; s_winc = 1'b0; rst_n = 1'b1;
    nvec++; if (s_count !== 4'd0) begin nerr++; $display("FAIL reset_count: got %0d want 0", s_count); end
    nvec++; if ({s_rempty, s_wfull, s_ae, s_af} !== 4'b1010) begin nerr++;
      $display("FAIL reset_flags: got e/f/ae/af=%b want 1010", {s_rempty, s_wfull, s_ae, s_af}); end
    nvec++; if (s_rdata !== 8'h00) begin nerr++; $display("FAIL reset_rdata: got %h want 00", s_rdata); end
    nvec++; if ({f_rempty, f_count, f_rdata} !== {1'b1, 4'd0, 8'h00}) begin nerr++;
      $display("FAIL reset_fwft: got e=%b cnt=%0d d=%h want 1/0/00", f_rempty, f_count, f_rdata); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    nvec++; if ({s_ovf, s_udf} !== 2'b00) begin nerr++; $display("FAIL reset_err: got %b want 00", {s_ovf, s_udf}); end
`endif
    s_cyc(1'b1, 8'h5A, 1'b0);
    s_cyc(1'b0, 8'h00, 1'b1);
    nvec++; if (s_rdata !== 8'h5A) begin nerr++; $display("FAIL reset_fresh_read: got %h want 5a", s_rdata); end
    nvec++; if ({s_count, s_rempty} !== {4'd0, 1'b1}) begin nerr++;
      $display("FAIL reset_after_read: got cnt=%0d e=%b want 0/1", s_count, s_rempty); end
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 8; i++) begin
      s_cyc(1'b1, 8'(i), 1'b0);
      nvec++; if (s_count !== 4'(i)) begin nerr++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, s_count, i); end
      nvec++; if ({s_af, s_wfull, s_ae, s_rempty} !== {(i >= 6), (i == 8), (i <= 1), 1'b0}) begin nerr++;
        $display("FAIL fill_flags[%0d]: got af/f/ae/e=%b want %b", i, {s_af, s_wfull, s_ae, s_rempty},
                 {(i >= 6), (i == 8), (i <= 1), 1'b0}); end
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    nvec++; if (s_ovf !== 1'b0) begin nerr++; $display("FAIL ovf_pre: got %b want 0", s_ovf); end
`endif
    s_cyc(1'b1, 8'hFF, 1'b0);
    nvec++; if ({s_count, s_wfull} !== {4'd8, 1'b1}) begin nerr++;
      $display("FAIL overfill: got cnt=%0d f=%b want 8/1", s_count, s_wfull); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    nvec++; if (s_ovf !== 1'b1) begin nerr++; $display("FAIL ovf_set: got %b want 1", s_ovf); end
    s_err_clr = 1'b1; s_cyc(1'b1, 8'hFE, 1'b0); s_err_clr = 1'b0;
    nvec++; if (s_ovf !== 1'b1) begin nerr++; $display("FAIL ovf_set_priority: got %b want 1", s_ovf); end
    s_err_clr = 1'b1; s_cyc(1'b0, 8'h00, 1'b0); s_err_clr = 1'b0;
    nvec++; if (s_ovf !== 1'b0) begin nerr++; $display("FAIL ovf_clear: got %b want 0", s_ovf); end
`endif
  endtask

  task automatic test_drain;
    for (int i = 1; i <= 8; i++) begin
      s_cyc(1'b0, 8'h00, 1'b1);
      nvec++; if (s_rdata !== 8'(i)) begin nerr++; $display("FAIL drain_data[%0d]: got %h want %h", i, s_rdata, 8'(i)); end
      nvec++; if ({s_count, s_rempty} !== {4'(8 - i), (i == 8)}) begin nerr++;
        $display("FAIL drain_state[%0d]: got cnt=%0d e=%b want %0d/%b", i, s_count, s_rempty, 8 - i, (i == 8)); end
    end
    s_cyc(1'b0, 8'h00, 1'b1);
    nvec++; if ({s_rdata, s_count} !== {8'h08, 4'd0}) begin nerr++;
      $display("FAIL underread: got d=%h cnt=%0d want 08/0", s_rdata, s_count); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    nvec++; if (s_udf !== 1'b1) begin nerr++; $display("FAIL udf_set: got %b want 1", s_udf); end
`endif
  endtask

  task automatic test_simul_bounds;
    for (int i = 0; i < 8; i++) s_cyc(1'b1, 8'h10 + 8'(i), 1'b0);
    s_cyc(1'b1, 8'hEE, 1'b1);
    nvec++; if ({s_count, s_wfull, s_rdata} !== {4'd7, 1'b0, 8'h10}) begin nerr++;
      $display("FAIL both_full: got cnt=%0d f=%b d=%h want 7/0/10", s_count, s_wfull, s_rdata); end
    for (int i = 1; i < 8; i++) begin
      s_cyc(1'b0, 8'h00, 1'b1);
      nvec++; if (s_rdata !== 8'h10 + 8'(i)) begin nerr++;
        $display("FAIL both_full_drain[%0d]: got %h want %h", i, s_rdata, 8'h10 + 8'(i)); end
    end
    s_cyc(1'b1, 8'hC3, 1'b1);
    nvec++; if ({s_count, s_rempty, s_rdata} !== {4'd1, 1'b0, 8'h17}) begin nerr++;
      $display("FAIL both_empty: got cnt=%0d e=%b d=%h want 1/0/17", s_count, s_rempty, s_rdata); end
    s_cyc(1'b0, 8'h00, 1'b1);
    nvec++; if ({s_rdata, s_count} !== {8'hC3, 4'd0}) begin nerr++;
      $display("FAIL both_empty_read: got d=%h cnt=%0d want c3/0", s_rdata, s_count); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 3; i++) s_cyc(1'b1, 8'h80 + 8'(i), 1'b0);
    for (int k = 0; k < 20; k++) begin
      s_cyc(1'b1, 8'h83 + 8'(k), 1'b1);
      nvec++; if (s_rdata !== 8'h80 + 8'(k)) begin nerr++;
        $display("FAIL wrap_data[%0d]: got %h want %h", k, s_rdata, 8'h80 + 8'(k)); end
      nvec++; if ({s_count, s_rempty, s_wfull, s_af, s_ae} !== {4'd3, 4'b0000}) begin nerr++;
        $display("FAIL wrap_flags[%0d]: got cnt=%0d e/f/af/ae=%b want 3/0000", k, s_count,
                 {s_rempty, s_wfull, s_af, s_ae}); end
    end
    for (int i = 0; i < 3; i++) begin
      s_cyc(1'b0, 8'h00, 1'b1);
      nvec++; if (s_rdata !== 8'h94 + 8'(i)) begin nerr++;
        $display("FAIL wrap_tail[%0d]: got %h want %h", i, s_rdata, 8'h94 + 8'(i)); end
    end
  endtask

  task automatic test_fwft;
    f_cyc(1'b1, 8'hA5, 1'b0);
    nvec++; if ({f_count, f_rempty} !== {4'd1, 1'b1}) begin nerr++;
      $display("FAIL fwft_edge_n: got cnt=%0d e=%b want 1/1", f_count, f_rempty); end
    f_cyc(1'b0, 8'h00, 1'b0);
    nvec++; if ({f_rempty, f_rdata} !== {1'b0, 8'hA5}) begin nerr++;
      $display("FAIL fwft_edge_n1: got e=%b d=%h want 0/a5", f_rempty, f_rdata); end
    f_cyc(1'b0, 8'h00, 1'b1);
    nvec++; if ({f_rempty, f_count, f_rdata} !== {1'b1, 4'd0, 8'hA5}) begin nerr++;
      $display("FAIL fwft_consume: got e=%b cnt=%0d d=%h want 1/0/a5", f_rempty, f_count, f_rdata); end
    for (int i = 0; i < 4; i++) f_cyc(1'b1, 8'hB0 + 8'(i), 1'b0);
    nvec++; if ({f_rempty, f_count, f_rdata} !== {1'b0, 4'd4, 8'hB0}) begin nerr++;
      $display("FAIL fwft_head: got e=%b cnt=%0d d=%h want 0/4/b0", f_rempty, f_count, f_rdata); end
    for (int k = 1; k <= 4; k++) begin
      f_cyc(1'b0, 8'h00, 1'b1);
      nvec++; if ({f_rempty, f_count} !== {(k == 4), 4'(4 - k)}) begin nerr++;
        $display("FAIL fwft_b2b_state[%0d]: got e=%b cnt=%0d want %b/%0d", k, f_rempty, f_count, (k == 4), 4 - k); end
      nvec++; if (f_rdata !== ((k == 4) ? 8'hB3 : 8'hB0 + 8'(k))) begin nerr++;
        $display("FAIL fwft_b2b_data[%0d]: got %h want %h", k, f_rdata, (k == 4) ? 8'hB3 : 8'hB0 + 8'(k)); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s_winc = 1'b0; s_rinc = 1'b0; s_wdata = '0;
    f_winc = 1'b0; f_rinc = 1'b0; f_wdata = '0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    s_err_clr = 1'b0; f_err_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_drain();
    test_simul_bounds();
    test_wrap();
    test_fwft();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
